// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time controller for the CLK_50 divided-clock output used by the clock
// viewer. Two configuration requesters offer new half-period terminal counts;
// a round-robin arbiter accepts one at a time into a shadow register, and the
// shadow value is applied glitch-free on the next output toggle (or on the
// next edge once the divider is stopped).
//
// Ports:
//   CLK_50      in   system clock, 50 MHz
//   rst         in   synchronous reset, active-high
//   run_en      in   1 = divider runs, 0 = stopped with clk_out held low
//   req0_valid  in   requester 0 offers req0_half
//   req0_half   in   requester 0 terminal count
//   req0_ready  out  requester 0 value accepted this cycle (combinational)
//   req1_valid  in   requester 1 offers req1_half
//   req1_half   in   requester 1 terminal count
//   req1_ready  out  requester 1 value accepted this cycle (combinational)
//   clk_out     out  divided clock, registered
//   tick        out  one-cycle pulse in the cycle clk_out changes by counting
//   half_cur    out  terminal count currently in effect
//   pending     out  shadow register holds a value not yet applied
//   cfg_err     out  one-cycle pulse: an accepted value was 0 and was dropped
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int               CNT_W        = 17,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(99999)
) (
    input  logic             CLK_50,
    input  logic             rst,
    input  logic             run_en,
    input  logic             req0_valid,
    input  logic [CNT_W-1:0] req0_half,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [CNT_W-1:0] req1_half,
    output logic             req1_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] half_cur,
    output logic             pending,
    output logic             cfg_err
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             rr_ptr;    // 0: req0 wins a tie, 1: req1 wins a tie
    logic             stopped;   // divider was already stopped on the previous edge

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [CNT_W-1:0] acc_val;
    logic             at_term;

    // -------------------------------------------------------------------------
    // Round-robin arbitration. Grants only from registered state plus the
    // requesters' valids; nothing is granted while a value waits in the shadow.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !pending) begin
            if (req0_valid && (!req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign acc_val    = grant0 ? req0_half : req1_half;
    assign at_term    = (cnt == half_cur);

    // -------------------------------------------------------------------------
    // Divider, shadow apply and accept. Accept needs pending=0 and apply needs
    // pending=1, so the two never update pending in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_50) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values of its neighbours, independent of order.
        if (rst) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            half_cur <= DEFAULT_HALF;
            shadow   <= '0;
            pending  <= 1'b0;
            cfg_err  <= 1'b0;
            rr_ptr   <= 1'b0;
            stopped  <= 1'b1;
        end else begin
            tick    <= 1'b0;
            cfg_err <= 1'b0;

            if (!run_en) begin
                // Forced low without a tick; a waiting value is applied only
                // once the stop has already taken effect on an earlier edge.
                cnt     <= '0;
                clk_out <= 1'b0;
                stopped <= 1'b1;
                if (pending && stopped) begin
                    half_cur <= shadow;
                    pending  <= 1'b0;
                end
            end else begin
                stopped <= 1'b0;
                if (at_term) begin
                    // The toggle closes the half period timed with the old
                    // value; the new one governs the half period starting now.
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                    if (pending) begin
                        half_cur <= shadow;
                        pending  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (accept) begin
                // The side just served loses the next tie.
                rr_ptr <= grant0;
                if (acc_val == '0) begin
                    cfg_err <= 1'b1;
                end else begin
                    shadow  <= acc_val;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed scenarios followed by a randomized run, all compared cycle by cycle
// against a behavioural model of the controller built from its rules: grant
// selection, accept/discard, apply at toggle or after stop, and the divider.
// A reduced DEFAULT_HALF keeps the reset-default scenarios short.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int CNT_W = 17;
    localparam int DEF   = 199;

    logic             CLK_50 = 1'b0;
    logic             rst = 1'b1;
    logic             run_en = 1'b0;
    logic             req0_valid = 1'b0;
    logic [CNT_W-1:0] req0_half = '0;
    logic             req1_valid = 1'b0;
    logic [CNT_W-1:0] req1_half = '0;
    logic             req0_ready;
    logic             req1_ready;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] half_cur;
    logic             pending;
    logic             cfg_err;

    int tests = 0;
    int fails = 0;

    clk_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (CNT_W'(DEF))
    ) dut (
        .CLK_50     (CLK_50),
        .rst        (rst),
        .run_en     (run_en),
        .req0_valid (req0_valid),
        .req0_half  (req0_half),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_half  (req1_half),
        .req1_ready (req1_ready),
        .clk_out    (clk_out),
        .tick       (tick),
        .half_cur   (half_cur),
        .pending    (pending),
        .cfg_err    (cfg_err)
    );

    always #5 CLK_50 = ~CLK_50;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt, m_half, m_shadow;
    bit m_clk, m_tick, m_pend, m_err, m_ptr, m_prev_run;
    bit last_r0, last_r1;

    function automatic void model_reset();
        m_cnt = 0; m_clk = 0; m_tick = 0; m_half = DEF; m_shadow = 0;
        m_pend = 0; m_err = 0; m_ptr = 0; m_prev_run = 0;
    endfunction

    // Who should be served right now: nobody while a value waits or in reset;
    // a lone requester always; on a tie, the side the pointer favours.
    function automatic void model_grants(output bit g0, output bit g1);
        g0 = 0;
        g1 = 0;
        if (!rst && !m_pend) begin
            if (req0_valid && (!req1_valid || !m_ptr)) g0 = 1;
            else if (req1_valid)                       g1 = 1;
        end
    endfunction

    function automatic void model_clock(input bit g0, input bit g1);
        bit apply;
        int v;
        if (rst) begin
            model_reset();
            return;
        end
        apply  = m_pend && (run_en ? (m_cnt == m_half) : !m_prev_run);
        m_tick = 0;
        m_err  = 0;
        if (run_en) begin
            if (m_cnt == m_half) begin
                m_cnt = 0; m_clk = !m_clk; m_tick = 1;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0; m_clk = 0;
        end
        m_prev_run = run_en;
        if (apply) begin
            m_half = m_shadow;
            m_pend = 0;
        end
        if (g0 || g1) begin
            v = g0 ? int'(req0_half) : int'(req1_half);
            m_ptr = g0;
            if (v == 0) m_err = 1;
            else begin m_shadow = v; m_pend = 1; end
        end
    endfunction

    // One clock: compare everything at the falling edge, then advance the model
    // with the same inputs the DUT sees at the rising edge.
    task automatic step();
        bit e0, e1;
        @(negedge CLK_50);
        model_grants(e0, e1);
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("clk_out", clk_out, m_clk);
        check("tick", tick, m_tick);
        check("half_cur", half_cur, m_half);
        check("pending", pending, m_pend);
        check("cfg_err", cfg_err, m_err);
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        @(posedge CLK_50);
        model_clock(e0, e1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; run_en = 0; req0_valid = 0; req1_valid = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic write_req(input bit side, input int val);
        int n;
        n = 0;
        if (!side) begin req0_valid = 1; req0_half = val[CNT_W-1:0]; end
        else       begin req1_valid = 1; req1_half = val[CNT_W-1:0]; end
        do begin
            step();
            n++;
        end while (!(side ? last_r1 : last_r0) && n < 50);
        check("write_granted", 32'(n < 50), 1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic count_to_tick(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < max);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n, total;
        int order[$];
        int exp_order[4];
        int grants;

        model_reset();
        @(posedge CLK_50);
        #1;

        // Reset values; ready stays low in reset even with a valid request.
        do_reset();
        rst = 1;
        req0_valid = 1;
        #1;
        check("rst_ready0", req0_ready, 0);
        req0_valid = 0;
        step();
        check("rst_half", half_cur, DEF);
        check("rst_clk", clk_out, 0);
        check("rst_pending", pending, 0);
        check("rst_tick", tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst = 0;

        // Default divide: first rise after DEF+1 cycles, period 2*(DEF+1).
        run_en = 1;
        count_to_tick(1000, n);
        check("first_rise", n, DEF + 1);
        check("first_rise_level", clk_out, 1);
        count_to_tick(1000, n);
        total = n;
        check("fall_level", clk_out, 0);
        count_to_tick(1000, n);
        total += n;
        check("default_period", total, 2 * (DEF + 1));

        // Load 3 while stopped, then write 9 mid half period.
        run_en = 0;
        step();
        write_req(0, 3);
        step();
        check("stop_apply_half", half_cur, 3);
        check("stop_apply_pend", pending, 0);
        run_en = 1;
        step();
        step();
        write_req(0, 9);
        check("mid_pending", pending, 1);
        check("mid_half_old", half_cur, 3);
        count_to_tick(20, n);
        check("apply_wait", n, 1);
        check("applied_half", half_cur, 9);
        check("applied_pend", pending, 0);
        count_to_tick(30, n);
        check("new_half_len", n, 10);

        // Round-robin: both valid, four grants alternate starting with req0.
        do_reset();
        req0_half = 11;
        req1_half = 22;
        req0_valid = 1;
        req1_valid = 1;
        grants = 0;
        n = 0;
        while (grants < 4 && n < 60) begin
            step();
            n++;
            if (last_r0) begin order.push_back(0); req0_half += 22; grants++; end
            if (last_r1) begin order.push_back(1); req1_half += 22; grants++; end
        end
        req0_valid = 0;
        req1_valid = 0;
        step();
        step();
        exp_order = '{0, 1, 0, 1};
        check("grant_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("grant_order", order[i], exp_order[i]);
        check("rr_final_half", half_cur, 44);

        // Zero value: one-cycle ready and cfg_err, nothing loaded.
        req1_valid = 1;
        req1_half = '0;
        step();
        check("zero_ready", last_r1, 1);
        req1_valid = 0;
        check("zero_cfg_err", cfg_err, 1);
        check("zero_pending", pending, 0);
        check("zero_half", half_cur, 44);
        step();
        check("zero_err_clear", cfg_err, 0);

        // All-ones terminal count is accepted and applied.
        write_req(1, (1 << CNT_W) - 1);
        step();
        check("all_ones_half", half_cur, (1 << CNT_W) - 1);

        // half=2: stop while high forces low without a tick, restart timing.
        write_req(0, 2);
        step();
        run_en = 1;
        count_to_tick(10, n);
        check("h2_first_rise", n, 3);
        check("h2_high", clk_out, 1);
        run_en = 0;
        step();
        check("stop_low", clk_out, 0);
        check("stop_no_tick", tick, 0);
        step();
        step();
        check("stop_hold", clk_out, 0);
        run_en = 1;
        count_to_tick(10, n);
        check("restart_rise", n, 3);
        check("restart_high", clk_out, 1);

        // Reset with a value pending: it is dropped, default is in effect.
        write_req(1, 7);
        check("pre_rst_pending", pending, 1);
        rst = 1;
        step();
        check("rst2_pending", pending, 0);
        check("rst2_half", half_cur, DEF);
        check("rst2_clk", clk_out, 0);
        check("rst2_tick", tick, 0);
        rst = 0;
        count_to_tick(1000, n);
        check("rst2_first_rise", n, DEF + 1);
        check("rst2_half_kept", half_cur, DEF);

        // Randomized traffic, checked every cycle against the model.
        do_reset();
        run_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            if (req0_valid && last_r0) req0_valid = 0;
            if (req1_valid && last_r1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 5) == 0) begin
                req0_valid = 1;
                req0_half = CNT_W'($urandom_range(0, 9));
            end
            if (!req1_valid && $urandom_range(0, 5) == 0) begin
                req1_valid = 1;
                req1_half = CNT_W'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 499) == 0) rst = 1;
            step();
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
